// File: rtl/wb_trace_buffer.sv
// wb_trace_buffer: captures committed register-file writes into a DEPTH-entry FIFO drained over valid/ready.
// Define WB_TRACE_PC_EN to also capture the commit PC in every entry; otherwise trace_pc is tied to 0.
module wb_trace_buffer #(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wb_valid,
  input  logic [4:0]        wb_reg,
  input  logic [31:0]       wb_data,
  input  logic [31:0]       wb_pc,
  input  logic              enable,
  input  logic              flush,
  output logic              trace_valid,
  input  logic              trace_ready,
  output logic [4:0]        trace_reg,
  output logic [31:0]       trace_data,
  output logic [31:0]       trace_pc,
  output logic [ADDR_W:0]   count,
  output logic              full,
  output logic              empty,
  output logic [15:0]       overflow_cnt
);

`ifdef WB_TRACE_PC_EN
  localparam int ENTRY_W = 69;
`else
  localparam int ENTRY_W = 37;
`endif
  localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W+1)'(DEPTH);

  logic [ENTRY_W-1:0] mem [DEPTH];
  logic [ENTRY_W-1:0] wrEntry;
  logic [ENTRY_W-1:0] headEntry;
  logic [ADDR_W-1:0]  wrPtr;
  logic [ADDR_W-1:0]  rdPtr;
  logic [ADDR_W:0]    occ;
  logic [15:0]        ovfCnt;
  logic               pushReq;
  logic               pushFire;
  logic               popFire;
  logic               dropEvt;

  // Handshake: an entry leaves on any rising edge where trace_valid and trace_ready are both high;
  // while trace_valid is high and trace_ready low, the head entry and outputs hold stable.
  assign pushReq  = wb_valid & enable & (wb_reg != 5'd0);
  assign popFire  = trace_valid & trace_ready;
  assign pushFire = pushReq & (!full | popFire);
  assign dropEvt  = pushReq & full & !popFire;

`ifdef WB_TRACE_PC_EN
  assign wrEntry = {wb_pc, wb_reg, wb_data};
`else
  logic unusedPc;
  assign unusedPc = ^wb_pc;
  assign wrEntry  = {wb_reg, wb_data};
`endif

  // Storage has no reset; the empty flag masks stale contents on the outputs.
  always_ff @(posedge clk) begin
    if (pushFire && !flush) begin
      mem[wrPtr] <= wrEntry;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wrPtr  <= '0;
      rdPtr  <= '0;
      occ    <= '0;
      ovfCnt <= '0;
    end else if (flush) begin
      wrPtr  <= '0;
      rdPtr  <= '0;
      occ    <= '0;
      ovfCnt <= '0;
    end else begin
      if (pushFire) wrPtr <= wrPtr + 1'b1;
      if (popFire)  rdPtr <= rdPtr + 1'b1;
      unique case ({pushFire, popFire})
        2'b10:   occ <= occ + 1'b1;
        2'b01:   occ <= occ - 1'b1;
        default: occ <= occ;
      endcase
      if (dropEvt && ovfCnt != 16'hFFFF) ovfCnt <= ovfCnt + 16'd1;
    end
  end

  assign headEntry    = mem[rdPtr];
  assign count        = occ;
  assign full         = (occ == FULL_CNT);
  assign empty        = (occ == '0);
  assign overflow_cnt = ovfCnt;
  assign trace_valid  = !empty;
  assign trace_reg    = empty ? 5'd0  : headEntry[36:32];
  assign trace_data   = empty ? 32'd0 : headEntry[31:0];
`ifdef WB_TRACE_PC_EN
  assign trace_pc     = empty ? 32'd0 : headEntry[68:37];
`else
  assign trace_pc     = 32'd0;
`endif

endmodule

// File: tb/tb_wb_trace_buffer.sv
// Directed bench for wb_trace_buffer: reset, stall, overflow, full push+pop, flush, async reset mid-drain.
// Expected PC follows WB_TRACE_PC_EN (0 when the macro is undefined).
module tb_wb_trace_buffer;
  logic        clk;
  logic        rst;
  logic        wb_valid;
  logic [4:0]  wb_reg;
  logic [31:0] wb_data;
  logic [31:0] wb_pc;
  logic        enable;
  logic        flush;
  logic        trace_valid;
  logic        trace_ready;
  logic [4:0]  trace_reg;
  logic [31:0] trace_data;
  logic [31:0] trace_pc;
  logic [4:0]  count;
  logic        full;
  logic        empty;
  logic [15:0] overflow_cnt;

  int total = 0;
  int bad   = 0;
  logic [68:0] expQ[$];

  wb_trace_buffer #(.DEPTH(16), .ADDR_W(4)) dut (
    .clk(clk), .rst(rst), .wb_valid(wb_valid), .wb_reg(wb_reg), .wb_data(wb_data),
    .wb_pc(wb_pc), .enable(enable), .flush(flush), .trace_valid(trace_valid),
    .trace_ready(trace_ready), .trace_reg(trace_reg), .trace_data(trace_data),
    .trace_pc(trace_pc), .count(count), .full(full), .empty(empty),
    .overflow_cnt(overflow_cnt)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkVal(input string tag, input logic [68:0] got, input logic [68:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] expPc(input logic [31:0] pc);
`ifdef WB_TRACE_PC_EN
    return pc;
`else
    return 32'd0;
`endif
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive one push for a single cycle; record it in the scoreboard only if it is expected to land.
  task automatic pushEvt(input logic [4:0] r, input logic [31:0] d, input logic [31:0] pc,
                         input bit accepted);
    wb_valid = 1'b1; wb_reg = r; wb_data = d; wb_pc = pc;
    if (accepted) expQ.push_back({expPc(pc), r, d});
    tick();
    wb_valid = 1'b0;
  endtask

  task automatic checkHead(input string tag);
    logic [68:0] e;
    if (expQ.size() == 0) begin
      checkVal({tag, "_sb_empty"}, 69'd1, 69'd0);
      return;
    end
    e = expQ[0];
    checkVal({tag, "_valid"}, 69'(trace_valid), 69'd1);
    checkVal({tag, "_reg"},   69'(trace_reg),   69'(e[36:32]));
    checkVal({tag, "_data"},  69'(trace_data),  69'(e[31:0]));
    checkVal({tag, "_pc"},    69'(trace_pc),    69'(e[68:37]));
  endtask

  task automatic drain(input int n, input string tag);
    trace_ready = 1'b1;
    for (int i = 0; i < n; i++) begin
      checkHead(tag);
      void'(expQ.pop_front());
      tick();
    end
  endtask

  task automatic checkResetOutputs(input string tag);
    checkVal({tag, "_valid"}, 69'(trace_valid),  69'd0);
    checkVal({tag, "_reg"},   69'(trace_reg),    69'd0);
    checkVal({tag, "_data"},  69'(trace_data),   69'd0);
    checkVal({tag, "_pc"},    69'(trace_pc),     69'd0);
    checkVal({tag, "_count"}, 69'(count),        69'd0);
    checkVal({tag, "_full"},  69'(full),         69'd0);
    checkVal({tag, "_empty"}, 69'(empty),        69'd1);
    checkVal({tag, "_ovf"},   69'(overflow_cnt), 69'd0);
  endtask

  initial begin
    rst = 1'b0; wb_valid = 1'b0; wb_reg = '0; wb_data = '0; wb_pc = '0;
    enable = 1'b1; flush = 1'b0; trace_ready = 1'b0;

    // reset state
    #3;
    checkResetOutputs("rst");
    tick();
    #2 rst = 1'b1;
    tick();
    checkResetOutputs("post_rst");

    // writes to $zero are never traced
    wb_valid = 1'b1; wb_reg = 5'd0; wb_data = 32'h1111_1111;
    for (int i = 0; i < 5; i++) begin
      tick();
      checkVal("zero_reg_count", 69'(count), 69'd0);
      checkVal("zero_reg_valid", 69'(trace_valid), 69'd0);
    end
    wb_valid = 1'b0;

    // capture disabled
    enable = 1'b0;
    pushEvt(5'd3, 32'h3333_3333, 32'h0, 1'b0);
    checkVal("disabled_count", 69'(count), 69'd0);
    enable = 1'b1;

    // single push, stalled head, then pop
    pushEvt(5'd8, 32'h0000_0005, 32'h0000_0010, 1'b1);
    checkHead("single");
    checkVal("single_count", 69'(count), 69'd1);
    for (int i = 0; i < 3; i++) begin
      tick();
      checkHead("stall");
    end
    drain(1, "single_pop");
    trace_ready = 1'b0;
    checkResetOutputs("after_pop");

    // 20 pushes into 16 entries: 4 dropped
    for (int i = 0; i < 20; i++)
      pushEvt(5'(i + 1), 32'hA000_0000 + 32'(i), 32'h100 + 32'(4 * i), i < 16);
    checkVal("ovf_full",  69'(full),         69'd1);
    checkVal("ovf_count", 69'(count),        69'd16);
    checkVal("ovf_cnt",   69'(overflow_cnt), 69'd4);
    drain(16, "ovf_drain");
    trace_ready = 1'b0;
    checkVal("ovf_drained_empty", 69'(empty), 69'd1);
    checkVal("ovf_cnt_kept", 69'(overflow_cnt), 69'd4);

    // full with simultaneous push and pop
    for (int i = 0; i < 16; i++)
      pushEvt(5'(i + 2), 32'hB000_0000 + 32'(i), 32'h200 + 32'(4 * i), 1'b1);
    checkVal("fpp_full", 69'(full), 69'd1);
    trace_ready = 1'b1;
    checkHead("fpp_head");
    void'(expQ.pop_front());
    pushEvt(5'd30, 32'hB000_0010, 32'h0000_0240, 1'b1);
    trace_ready = 1'b0;
    checkVal("fpp_count", 69'(count),        69'd16);
    checkVal("fpp_ovf",   69'(overflow_cnt), 69'd4);
    drain(16, "fpp_drain");
    trace_ready = 1'b0;
    checkVal("fpp_empty", 69'(empty), 69'd1);

    // flush alone clears the overflow counter
    flush = 1'b1;
    tick();
    flush = 1'b0;
    checkVal("flush0_ovf", 69'(overflow_cnt), 69'd0);

    // build count=5, overflow_cnt=3, then flush together with a push
    for (int i = 0; i < 19; i++)
      pushEvt(5'(i + 1), 32'hC000_0000 + 32'(i), 32'h300 + 32'(4 * i), i < 16);
    checkVal("pre_flush_ovf", 69'(overflow_cnt), 69'd3);
    drain(11, "pre_flush_drain");
    trace_ready = 1'b0;
    checkVal("pre_flush_count", 69'(count), 69'd5);
    flush = 1'b1;
    pushEvt(5'd31, 32'hDEAD_BEEF, 32'h0000_0400, 1'b0);
    flush = 1'b0;
    expQ.delete();
    checkResetOutputs("flush");
    tick();
    checkVal("flush_push_absent", 69'(count), 69'd0);

    // asynchronous reset mid-drain at count=7
    for (int i = 0; i < 9; i++)
      pushEvt(5'(i + 10), 32'hD000_0000 + 32'(i), 32'h500 + 32'(4 * i), 1'b1);
    drain(2, "pre_rst_drain");
    checkVal("pre_rst_count", 69'(count), 69'd7);
    #2 rst = 1'b0;
    #1;
    checkResetOutputs("mid_rst");
    tick();
    checkResetOutputs("mid_rst_edge");
    #2 rst = 1'b1;
    trace_ready = 1'b0;
    expQ.delete();
    tick();
    checkResetOutputs("rst_release");
    pushEvt(5'd12, 32'h0000_1234, 32'h0000_0040, 1'b1);
    checkHead("post_rst_push");
    drain(1, "post_rst_pop");
    trace_ready = 1'b0;
    checkVal("final_empty", 69'(empty), 69'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/wb_trace_buffer.md
# wb_trace_buffer

Writeback-commit trace buffer that sits directly downstream of the pipelined datapath's write-back stage. Every committed register-file write (register number, write data, optionally the PC) is captured into a DEPTH-entry FIFO and drained through a valid/ready port to a testbench monitor, logic analyser or UART dumper. It never back-pressures the pipeline: when the buffer is full, new events are dropped and counted.

## Interface
- DEPTH, 16, number of FIFO entries; power of two, ≥ 2
- ADDR_W, 4, log2(DEPTH)
- clk  input  1  pipeline clock; all state updates on rising edge
- rst  input  1  reset, asynchronous, active-low
- wb_valid  input  1  RegWrite qualifier from the WB stage
- wb_reg  input  5  destination register from the WB stage
- wb_data  input  32  value written to the register file (WriteData)
- wb_pc  input  32  ProgramCounter sampled alongside the commit
- enable  input  1  capture enable; 0 blocks new pushes
- flush  input  1  synchronous clear of FIFO contents and overflow count
- trace_valid  output  1  head entry available
- trace_ready  input  1  consumer accepts head entry
- trace_reg  output  5  head entry register number
- trace_data  output  32  head entry data
- trace_pc  output  32  head entry PC
- count  output  ADDR_W+1  occupancy, 0..DEPTH
- full  output  1  count == DEPTH
- empty  output  1  count == 0
- overflow_cnt  output  16  dropped-event counter, saturating

## Operation
- Push request: wb_valid & enable & (wb_reg != 0); writes to $zero are never traced.
- Pop: trace_valid & trace_ready.
- Push accepted when !full, or when full with a pop in the same cycle (both occur, count unchanged).
- Push request while full with no pop: event dropped; overflow_cnt += 1, saturating at 16'hFFFF.
- Pointers wr_ptr/rd_ptr are ADDR_W bits and wrap modulo DEPTH; count tracks occupancy separately.
- trace_valid = !empty. While empty, trace_reg/trace_data/trace_pc are forced to 0.
- While trace_valid & !trace_ready, the head outputs hold stable.
- flush: pointers, count and overflow_cnt return to 0 in the next cycle. Any push or pop in the same cycle is discarded, and a discarded push does not increment overflow_cnt.
- Storage array is not reset; only pointers, count and overflow_cnt are reset.

## Timing
- Reset (rst low, asynchronous): trace_valid=0, trace_reg=0, trace_data=0, trace_pc=0, count=0, full=0, empty=1, overflow_cnt=0. Takes effect immediately and holds until the first clk edge after rst rises.
- Reset mid-operation discards all contents without completing any handshake.
- Latency: push at edge N appears on the outputs (trace_valid=1) after edge N. There is no same-cycle bypass from wb_* to trace_*.
- Push into an empty buffer with trace_ready=1: the entry is popped on edge N+1 at the earliest.
- Sustained throughput: one push and one pop per cycle.
- count, full, empty and overflow_cnt are registered and update on the same edge as the push/pop that changes them.

## Configuration
- WB_TRACE_PC_EN defined: each entry is 69 bits {pc, reg, data}; trace_pc returns the captured wb_pc.
- WB_TRACE_PC_EN undefined: each entry is 37 bits {reg, data}; wb_pc is ignored; trace_pc is tied to 32'h0. All other behaviour is identical.

## Test plan
- Reset then idle: all outputs at reset values; wb_valid=1 with wb_reg=0 for 5 cycles -> count stays 0, trace_valid stays 0.
- Push (reg=8, data=32'h0000_0005, pc=32'h0000_0010) with trace_ready=0 -> next cycle trace_valid=1 with those values; values hold for 3 stalled cycles; pop with trace_ready=1 -> empty=1 and outputs return to 0.
- DEPTH=16: push 20 distinct events with trace_ready=0 -> full=1, count=16, overflow_cnt=4. Draining returns events 1..16 in order.
- While full, push and pop in the same cycle -> count stays 16, overflow_cnt unchanged, new event lands at the tail. Push 17 entries total so wr_ptr wraps -> drain order correct.
- flush asserted together with a push while count=5 and overflow_cnt=3 -> next cycle count=0, empty=1, overflow_cnt=0, and the pushed event is absent.
- rst pulsed low mid-drain (count=7) between clock edges -> outputs reset immediately; after release, new pushes are traced normally. Repeat with WB_TRACE_PC_EN undefined -> trace_pc always 0.
